// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
//
// Priority interrupt controller between peripheral request lines and the
// RISC-V core's interrupt entry. Rising edges on the request lines are latched
// into a pending register and masked with the core's mie CSR (bit 16+k enables
// line k). The lowest-numbered eligible line wins. It is presented to the core
// with its mcause value, and the controller then sequences the take-interrupt
// and mret handshake. A one-cycle one-hot acknowledge goes back to the serviced
// peripheral.
//
// Ports:
//   clk_i      core clock, rising-edge active
//   rst_i      synchronous active-high reset
//   irq_i      peripheral request lines (level, a 0->1 transition is an event)
//   mie_i      core mie CSR; bits [16 +: N_IRQ] enable the request lines
//   int_rst_i  one-cycle pulse: the core has taken the presented interrupt
//   mret_i     one-cycle pulse: the handler has executed mret
//   int_o      interrupt request to the core
//   mcause_o   cause of the presented / serviced interrupt
//   irq_ack_o  one-hot, one-cycle acknowledge to the serviced peripheral
//   pending_o  raw pending register, for visibility
//
// All outputs are registered. No combinational path runs from input to output.
// -----------------------------------------------------------------------------
module irq_controller #(
  parameter int N_IRQ = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_IRQ-1:0]  irq_i,
  input  logic [31:0]       mie_i,
  input  logic              int_rst_i,
  input  logic              mret_i,
  output logic              int_o,
  output logic [31:0]       mcause_o,
  output logic [N_IRQ-1:0]  irq_ack_o,
  output logic [N_IRQ-1:0]  pending_o
);

  // Machine external-style interrupt cause: interrupt flag plus 16 + line.
  localparam logic [31:0] CAUSE_BASE = 32'h8000_0010;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Index of the lowest set bit; 0 when the vector is empty (callers only
  // use the result when the vector is non-zero).
  function automatic logic [3:0] lowest_set(input logic [N_IRQ-1:0] vec);
    logic [3:0] res;
    res = 4'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      res = vec[i] ? 4'(i) : res;
    end
    return res;
  endfunction

  // One-hot decode of a line index into an N_IRQ-wide vector.
  function automatic logic [N_IRQ-1:0] one_hot(input logic [3:0] idx);
    logic [N_IRQ-1:0] res;
    res = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      res[i] = (4'(i) == idx);
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_r;
  state_t             state_n_s;
  logic [N_IRQ-1:0]   irq_q_r;
  logic [N_IRQ-1:0]   pending_r;
  logic [N_IRQ-1:0]   pending_n_s;
  logic [3:0]         sel_r;
  logic [3:0]         sel_n_s;
  logic               int_r;
  logic               int_n_s;
  logic [31:0]        mcause_r;
  logic [31:0]        mcause_n_s;
  logic [N_IRQ-1:0]   ack_r;
  logic [N_IRQ-1:0]   ack_n_s;

  logic [N_IRQ-1:0]   edge_s;
  logic [N_IRQ-1:0]   mie_en_s;
  logic [N_IRQ-1:0]   elig_s;
  logic [N_IRQ-1:0]   sel_hot_s;
  logic               sel_enabled_s;
  logic               mie_unused_s;

  assign edge_s        = irq_i & ~irq_q_r;
  assign mie_en_s      = mie_i[16 +: N_IRQ];
  assign elig_s        = pending_r & mie_en_s;
  assign sel_hot_s     = one_hot(sel_r);
  assign sel_enabled_s = |(sel_hot_s & mie_en_s);

  // Only the line-enable bits of mie matter here. The rest are folded away.
  assign mie_unused_s  = ^mie_i;

  // Next-state, pending update and next registered outputs.
  always_comb begin
    state_n_s   = state_r;
    pending_n_s = pending_r | edge_s;
    sel_n_s     = sel_r;
    int_n_s     = int_r;
    mcause_n_s  = mcause_r;
    ack_n_s     = '0;

    case (state_r)
      ST_IDLE: begin
        if (|elig_s) begin
          // Winner and cause are captured here and stay frozen until the
          // next return to IDLE, so a later higher-priority edge cannot preempt.
          state_n_s  = ST_REQ;
          sel_n_s    = lowest_set(elig_s);
          mcause_n_s = CAUSE_BASE + {28'd0, lowest_set(elig_s)};
          int_n_s    = 1'b1;
        end else begin
          int_n_s    = 1'b0;
        end
      end

      ST_REQ: begin
        if (int_rst_i) begin
          // The take-interrupt pulse beats a simultaneous mask drop. A fresh edge
          // on the same line in this cycle re-sets the bit (set wins over clear).
          state_n_s   = ST_SERVICE;
          int_n_s     = 1'b0;
          ack_n_s     = sel_hot_s;
          pending_n_s = (pending_r & ~sel_hot_s) | edge_s;
        end else if (!sel_enabled_s) begin
          // Line masked while waiting: withdraw, pending bit stays set.
          state_n_s   = ST_IDLE;
          int_n_s     = 1'b0;
        end else begin
          int_n_s     = 1'b1;
        end
      end

      ST_SERVICE: begin
        int_n_s = 1'b0;
        if (mret_i) begin
          state_n_s = ST_IDLE;
        end else begin
          state_n_s = ST_SERVICE;
        end
      end

      default: begin
        state_n_s = ST_IDLE;
        int_n_s   = 1'b0;
      end
    endcase
  end

  // State, pending and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      irq_q_r   <= '0;
      pending_r <= '0;
      sel_r     <= 4'd0;
      int_r     <= 1'b0;
      mcause_r  <= 32'd0;
      ack_r     <= '0;
    end else begin
      state_r   <= state_n_s;
      irq_q_r   <= irq_i;
      pending_r <= pending_n_s;
      sel_r     <= sel_n_s;
      int_r     <= int_n_s;
      mcause_r  <= mcause_n_s;
      ack_r     <= ack_n_s;
    end
  end

  assign int_o     = int_r;
  assign mcause_o  = mcause_r;
  assign irq_ack_o = ack_r;
  assign pending_o = pending_r;

endmodule

// File: tb/tb_irq_controller.sv
// -----------------------------------------------------------------------------
// tb_irq_controller
//
// Directed bench for irq_controller. The stimulus process pushes the expected
// observable output tuple into a scoreboard, tagged with the cycle at which it
// must appear. A monitor samples the outputs on every falling edge. Whenever
// the tuple changes, it pops the next expectation and compares both the value
// and the cycle. An output change with nothing expected is an error, and so
// is an expectation left in the queue at the end.
// -----------------------------------------------------------------------------
module tb_irq_controller;

  typedef struct packed {
    logic        irq;
    logic [31:0] cause;
    logic [15:0] ack;
    logic [15:0] pend;
  } obs_t;

  typedef struct {
    string tag;
    int    cyc;
    obs_t  obs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] irq;
  logic [31:0] mie;
  logic        int_rst;
  logic        mret;
  logic        int_o;
  logic [31:0] mcause;
  logic [15:0] irq_ack;
  logic [15:0] pending;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;
  exp_t sb_q[$];
  obs_t prev_obs = '0;

  irq_controller #(.N_IRQ(16)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .irq_i     (irq),
    .mie_i     (mie),
    .int_rst_i (int_rst),
    .mret_i    (mret),
    .int_o     (int_o),
    .mcause_o  (mcause),
    .irq_ack_o (irq_ack),
    .pending_o (pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare on every change of the observable outputs.
  always @(negedge clk) begin
    obs_t cur;
    exp_t e;
    cur = {int_o, mcause, irq_ack, pending};
    if (cyc == 1 || cur != prev_obs) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_change cyc=%0d got int=%0b mcause=%h ack=%h pend=%h",
                 cyc, cur.irq, cur.cause, cur.ack, cur.pend);
      end else begin
        e = sb_q.pop_front();
        if (e.cyc != cyc || e.obs != cur) begin
          n_mis++;
          $display("FAIL %s got cyc=%0d int=%0b mcause=%h ack=%h pend=%h, want cyc=%0d int=%0b mcause=%h ack=%h pend=%h",
                   e.tag, cyc, cur.irq, cur.cause, cur.ack, cur.pend,
                   e.cyc, e.obs.irq, e.obs.cause, e.obs.ack, e.obs.pend);
        end
      end
    end
    prev_obs = cur;
  end

  // Advance n cycles; inputs driven afterwards are sampled at the next edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Expect the given output tuple dt cycles from now.
  task automatic exp_at(input string tag, input int dt, input logic i,
                        input logic [31:0] c, input logic [15:0] a,
                        input logic [15:0] p);
    exp_t e;
    e.tag = tag;
    e.cyc = cyc + dt;
    e.obs = {i, c, a, p};
    sb_q.push_back(e);
  endtask

  task automatic pulse_int_rst();
    int_rst = 1'b1;
    step(1);
    int_rst = 1'b0;
  endtask

  task automatic pulse_mret();
    mret = 1'b1;
    step(1);
    mret = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst     = 1'b1;
    irq     = 16'h0000;
    mie     = 32'h0000_0000;
    int_rst = 1'b0;
    mret    = 1'b0;

    // Reset state
    exp_at("reset_state", 1, 1'b0, 32'h0000_0000, 16'h0000, 16'h0000);
    step(2);
    rst = 1'b0;
    step(2);

    // Single event on line 0
    mie    = 32'h0001_0000;
    irq[0] = 1'b1;
    exp_at("t1_pending", 1, 1'b0, 32'h0000_0000, 16'h0000, 16'h0001);
    exp_at("t1_present", 2, 1'b1, 32'h8000_0010, 16'h0000, 16'h0001);
    step(5);
    exp_at("t1_ack",     1, 1'b0, 32'h8000_0010, 16'h0001, 16'h0000);
    exp_at("t1_ack_off", 2, 1'b0, 32'h8000_0010, 16'h0000, 16'h0000);
    pulse_int_rst();
    step(4);
    pulse_mret();
    irq = 16'h0000;
    step(2);

    // Priority: lines 3 and 1 together
    mie = 32'hFFFF_0000;
    irq = 16'h000A;
    exp_at("t2_pending",  1, 1'b0, 32'h8000_0010, 16'h0000, 16'h000A);
    exp_at("t2_line1",    2, 1'b1, 32'h8000_0011, 16'h0000, 16'h000A);
    step(3);
    exp_at("t2_ack1",     1, 1'b0, 32'h8000_0011, 16'h0002, 16'h0008);
    exp_at("t2_ack1_off", 2, 1'b0, 32'h8000_0011, 16'h0000, 16'h0008);
    pulse_int_rst();
    step(3);
    exp_at("t2_line3",    2, 1'b1, 32'h8000_0013, 16'h0000, 16'h0008);
    pulse_mret();
    step(2);
    exp_at("t2_ack3",     1, 1'b0, 32'h8000_0013, 16'h0008, 16'h0000);
    exp_at("t2_ack3_off", 2, 1'b0, 32'h8000_0013, 16'h0000, 16'h0000);
    pulse_int_rst();
    step(2);
    pulse_mret();
    irq = 16'h0000;
    step(2);

    // Masking and withdraw on line 2
    mie    = 32'hFFFB_0000;
    irq[2] = 1'b1;
    exp_at("t3_pending", 1, 1'b0, 32'h8000_0013, 16'h0000, 16'h0004);
    step(51);
    mie = 32'hFFFF_0000;
    exp_at("t3_unmask",  1, 1'b1, 32'h8000_0012, 16'h0000, 16'h0004);
    step(3);
    mie = 32'hFFFB_0000;
    exp_at("t3_withdraw", 1, 1'b0, 32'h8000_0012, 16'h0000, 16'h0004);
    step(3);

    // Re-edge on the served line in the take-interrupt cycle
    irq[4] = 1'b1;
    exp_at("t4_pending", 1, 1'b0, 32'h8000_0012, 16'h0000, 16'h0014);
    exp_at("t4_present", 2, 1'b1, 32'h8000_0014, 16'h0000, 16'h0014);
    step(2);
    irq[4] = 1'b0;
    step(1);
    irq[4] = 1'b1;
    exp_at("t4_set_wins",    1, 1'b0, 32'h8000_0014, 16'h0010, 16'h0014);
    exp_at("t4_ack_off",     2, 1'b0, 32'h8000_0014, 16'h0000, 16'h0014);
    pulse_int_rst();
    step(3);
    exp_at("t4_represent",   2, 1'b1, 32'h8000_0014, 16'h0000, 16'h0014);
    pulse_mret();
    step(2);
    exp_at("t4_ack2",        1, 1'b0, 32'h8000_0014, 16'h0010, 16'h0004);
    exp_at("t4_ack2_off",    2, 1'b0, 32'h8000_0014, 16'h0000, 16'h0004);
    pulse_int_rst();
    step(2);
    pulse_mret();
    irq[4] = 1'b0;
    step(2);

    // No preemption by line 0 during line 5, spurious pulses ignored
    irq[5] = 1'b1;
    exp_at("t5_pending",   1, 1'b0, 32'h8000_0014, 16'h0000, 16'h0024);
    exp_at("t5_present",   2, 1'b1, 32'h8000_0015, 16'h0000, 16'h0024);
    step(2);
    irq[0] = 1'b1;
    exp_at("t5_no_preempt", 1, 1'b1, 32'h8000_0015, 16'h0000, 16'h0025);
    step(2);
    pulse_mret();
    step(2);
    exp_at("t5_ack5",      1, 1'b0, 32'h8000_0015, 16'h0020, 16'h0005);
    exp_at("t5_ack5_off",  2, 1'b0, 32'h8000_0015, 16'h0000, 16'h0005);
    pulse_int_rst();
    step(4);
    pulse_int_rst();
    step(3);
    exp_at("t5_line0",     2, 1'b1, 32'h8000_0010, 16'h0000, 16'h0005);
    pulse_mret();
    step(2);
    exp_at("t5_ack0",      1, 1'b0, 32'h8000_0010, 16'h0001, 16'h0004);
    exp_at("t5_ack0_off",  2, 1'b0, 32'h8000_0010, 16'h0000, 16'h0004);
    pulse_int_rst();
    step(2);

    // Reset while in service with three lines pending
    irq = 16'h0004;
    step(1);
    irq = 16'h00A4;
    exp_at("t6_pending3",  1, 1'b0, 32'h8000_0010, 16'h0000, 16'h00A4);
    step(2);
    irq = 16'h0000;
    step(1);
    rst = 1'b1;
    exp_at("t6_reset",     1, 1'b0, 32'h0000_0000, 16'h0000, 16'h0000);
    step(1);
    rst = 1'b0;
    step(20);
    irq[1] = 1'b1;
    exp_at("t6_fresh_pend", 1, 1'b0, 32'h0000_0000, 16'h0000, 16'h0002);
    exp_at("t6_fresh_req",  2, 1'b1, 32'h8000_0011, 16'h0000, 16'h0002);
    step(4);

    // Any expectation never met counts against the run.
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_cmp++;
      n_mis++;
      $display("FAIL %s never observed (want cyc=%0d), run ended at cyc=%0d", e.tag, e.cyc, cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
